axi_lite_slave_regs: RTL and testbench

AXI4-Lite slave register file that sits directly downstream of the team's AXI-Lite master and terminates its AW/W/B/AR/R channels. It holds 2**(ADDR_W-2) word registers and exposes their contents to fabric logic. It accepts AW and W independently, in either order. It returns one B response per write and one R beat per read.

---
 rtl/axi_lite_slave_regs_if.sv | 25 ++
 rtl/axi_lite_slave_regs.sv | 94 +++++++++
 tb/tb_axi_lite_slave_regs.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_slave_regs_if.sv
// axi_lite_slave_regs_if: AXI4-Lite AW/W/B/AR/R channel bundle
interface axi_lite_slave_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] AWADDR;
  logic AWVALID, AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic WVALID, WREADY;
  logic [1:0] BRESP;
  logic BVALID, BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic ARVALID, ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0] RRESP;
  logic RVALID, RREADY;
  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport slave (
    input AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite register file; define AXIL_SLVERR_EN to reject misaligned addresses with SLVERR
module axi_lite_slave_regs #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic ACLK,
  input  logic ARESET,
  axi_lite_slave_regs_if.slave bus,
  output logic [(2**(ADDR_W-2))*DATA_W-1:0] reg_out
);
  localparam int NUM_REGS = 2**(ADDR_W-2);
`ifdef AXIL_SLVERR_EN
  localparam bit SLVERR = 1'b1;
`else
  localparam bit SLVERR = 1'b0;
`endif
  typedef enum logic {WR_IDLE, WR_RESP} wr_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_t;
  wr_t wr_state, wr_next;
  rd_t rd_state, rd_next;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic aw_got, w_got;
  logic [ADDR_W-1:0] aw_addr_q, wr_addr;
  logic [DATA_W-1:0] w_data_q, wr_data, rdata_q;
  logic [1:0] bresp_q, rresp_q;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_err, rd_err;
  always_ff @(posedge ACLK) begin
    wr_state <= ARESET ? WR_IDLE : wr_next;
    rd_state <= ARESET ? RD_IDLE : rd_next;
  end
  // Commit counts handshakes of this cycle, so AW and W may arrive in any order or together
  always_comb begin
    bus.AWREADY = !ARESET && wr_state == WR_IDLE && !aw_got;
    bus.WREADY = !ARESET && wr_state == WR_IDLE && !w_got;
    bus.BVALID = wr_state == WR_RESP;
    bus.BRESP = bresp_q;
    aw_hs = bus.AWVALID && bus.AWREADY;
    w_hs = bus.WVALID && bus.WREADY;
    b_hs = bus.BVALID && bus.BREADY;
    wr_addr = aw_got ? aw_addr_q : bus.AWADDR;
    wr_data = w_got ? w_data_q : bus.WDATA;
    wr_err = SLVERR && wr_addr[1:0] != 2'b00;
    commit = wr_state == WR_IDLE && (aw_got || aw_hs) && (w_got || w_hs);
    wr_next = commit ? WR_RESP : b_hs ? WR_IDLE : wr_state;
  end
  always_comb begin
    bus.ARREADY = !ARESET && rd_state == RD_IDLE;
    bus.RVALID = rd_state == RD_DATA;
    bus.RDATA = rdata_q;
    bus.RRESP = rresp_q;
    ar_hs = bus.ARVALID && bus.ARREADY;
    r_hs = bus.RVALID && bus.RREADY;
    rd_err = SLVERR && bus.ARADDR[1:0] != 2'b00;
    rd_next = ar_hs ? RD_DATA : r_hs ? RD_IDLE : rd_state;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_addr_q <= '0;
      w_data_q <= '0;
      bresp_q <= 2'b00;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_addr_q <= bus.AWADDR;
      end
      if (w_hs) begin
        w_got <= 1'b1;
        w_data_q <= bus.WDATA;
      end
      if (commit) begin
        if (!wr_err) regs[wr_addr[ADDR_W-1:2]] <= wr_data;
        bresp_q <= wr_err ? 2'b10 : 2'b00;
      end
      if (b_hs) begin
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end
      // Reads sample regs before this edge's write lands, giving pre-write data on a same-edge collision
      if (ar_hs) begin
        rdata_q <= rd_err ? '0 : regs[bus.ARADDR[ADDR_W-1:2]];
        rresp_q <= rd_err ? 2'b10 : 2'b00;
      end
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[i*DATA_W +: DATA_W] = regs[i];
  end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: scoreboard bench for axi_lite_slave_regs (honours AXIL_SLVERR_EN)
module tb_axi_lite_slave_regs;
  logic ACLK = 1'b0;
  logic ARESET;
  logic [127:0] reg_out;
  always #5 ACLK = ~ACLK;
  axi_lite_slave_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();
  axi_lite_slave_regs #(.ADDR_W(4), .DATA_W(32), .RESET_VAL(32'h0)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .reg_out(reg_out)
  );
`ifdef AXIL_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif
  int n = 0;
  int errs = 0;
  logic [31:0] model [4];
  logic [33:0] rq[$];
  logic [1:0] bq[$];

  function automatic logic [33:0] exp_rd(input logic [3:0] a);
    return (SLV && a[1:0] != 2'b00) ? 34'b10 : {model[a[3:2]], 2'b00};
  endfunction

  function automatic logic [1:0] exp_wr(input logic [3:0] a, input logic [31:0] d);
    if (SLV && a[1:0] != 2'b00) return 2'b10;
    model[a[3:2]] = d;
    return 2'b00;
  endfunction

  task automatic rd(input logic [3:0] a, input int hold, output logic [31:0] d,
                    output logic [1:0] r, output bit lat_ok, output bit stable);
    int t;
    @(negedge ACLK);
    bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    t = 0;
    while (!bus.ARREADY && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    lat_ok = bus.RVALID && t < 50;
    d = bus.RDATA; r = bus.RRESP; stable = 1'b1;
    repeat (hold) begin
      @(negedge ACLK);
      if (!bus.RVALID || bus.RDATA !== d || bus.RRESP !== r || bus.ARREADY) stable = 1'b0;
    end
    bus.RREADY = 1'b1;
    @(negedge ACLK);
    bus.RREADY = 1'b0;
    if (bus.RVALID) stable = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input int lead, input int bhold,
                    output logic [1:0] resp, output bit ok);
    int t;
    ok = 1'b1;
    @(negedge ACLK);
    bus.WDATA = d; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    if (lead > 0) begin
      t = 0;
      while (!bus.WREADY && t < 50) begin @(negedge ACLK); t++; end
      if (t >= 50) ok = 1'b0;
      @(negedge ACLK);
      bus.WVALID = 1'b0;
      repeat (lead - 1) begin
        if (bus.BVALID || bus.WREADY) ok = 1'b0;
        @(negedge ACLK);
      end
      if (bus.BVALID || bus.WREADY) ok = 1'b0;
    end
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    t = 0;
    while (!(bus.AWREADY && (lead > 0 || bus.WREADY)) && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) ok = 1'b0;
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    if (!bus.BVALID) ok = 1'b0;
    resp = bus.BRESP;
    repeat (bhold) begin
      if (!bus.BVALID || bus.BRESP !== resp || bus.AWREADY || bus.WREADY) ok = 1'b0;
      @(negedge ACLK);
    end
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    bus.BREADY = 1'b0;
    if (bus.BVALID) ok = 1'b0;
  endtask

  task automatic test_reset;
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    n++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b0) begin
      errs++; $display("FAIL reset_ctl got %b exp 00000", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID});
    end
    n++;
    if ({bus.BRESP, bus.RRESP, bus.RDATA, reg_out} !== '0) begin
      errs++; $display("FAIL reset_data got %h/%h/%h/%h exp 0", bus.BRESP, bus.RRESP, bus.RDATA, reg_out);
    end
    ARESET = 1'b0;
    #1;
    n++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
      errs++; $display("FAIL post_reset_ready got %b exp 111", {bus.AWREADY, bus.WREADY, bus.ARREADY});
    end
  endtask

  task automatic test_read_zero;
    logic [31:0] d; logic [1:0] r; bit lo, st; logic [33:0] e;
    for (int i = 0; i < 4; i++) begin
      rq.push_back(exp_rd(4'(i * 4)));
      rd(4'(i * 4), 0, d, r, lo, st);
      e = rq.pop_front();
      n++;
      if ({d, r} !== e || !lo || !st) begin
        errs++; $display("FAIL read_zero_%0d got %h/%b lat=%0d st=%0d exp %h/%b", i, d, r, lo, st, e[33:2], e[1:0]);
      end
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      n++;
      if (reg_out[i*32 +: 32] !== model[i]) begin
        errs++; $display("FAIL %s_reg%0d got %h exp %h", tag, i, reg_out[i*32 +: 32], model[i]);
      end
    end
  endtask

  task automatic test_write_read(input string tag, input logic [3:0] a, input logic [31:0] d,
                                 input int lead, input int bhold, input int rhold);
    logic [31:0] rdat; logic [1:0] r, e2; bit ok, lo, st; logic [33:0] e;
    bq.push_back(exp_wr(a, d));
    wr(a, d, lead, bhold, r, ok);
    e2 = bq.pop_front();
    n++;
    if (r !== e2 || !ok) begin
      errs++; $display("FAIL %s_bresp got %b ok=%0d exp %b ok=1", tag, r, ok, e2);
    end
    check_regs(tag);
    rq.push_back(exp_rd(a));
    rd(a, rhold, rdat, r, lo, st);
    e = rq.pop_front();
    n++;
    if ({rdat, r} !== e || !lo || !st) begin
      errs++; $display("FAIL %s_read got %h/%b lat=%0d st=%0d exp %h/%b", tag, rdat, r, lo, st, e[33:2], e[1:0]);
    end
  endtask

  task automatic test_same_edge;
    logic [33:0] e;
    @(negedge ACLK);
    rq.push_back(exp_rd(4'h8));
    bq.push_back(exp_wr(4'h8, 32'hA5A5A5A5));
    bus.AWADDR = 4'h8; bus.AWVALID = 1'b1;
    bus.WDATA = 32'hA5A5A5A5; bus.WVALID = 1'b1;
    bus.ARADDR = 4'h8; bus.ARVALID = 1'b1;
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    e = rq.pop_front();
    n++;
    if (!bus.RVALID || {bus.RDATA, bus.RRESP} !== e) begin
      errs++; $display("FAIL same_edge_read got %h/%b v=%0d exp %h/00", bus.RDATA, bus.RRESP, bus.RVALID, e[33:2]);
    end
    n++;
    if (!bus.BVALID || bus.BRESP !== bq.pop_front()) begin
      errs++; $display("FAIL same_edge_bresp got %b v=%0d exp 00", bus.BRESP, bus.BVALID);
    end
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(negedge ACLK);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    check_regs("same_edge");
    test_write_read("after_same_edge", 4'h8, 32'hA5A5A5A5, 0, 0, 0);
  endtask

  task automatic test_misaligned;
    logic [31:0] d; logic [1:0] r; bit lo, st; logic [33:0] e;
    test_write_read("misaligned_w", 4'h6, 32'hFFFFFFFF, 0, 0, 0);
    rq.push_back(exp_rd(4'h3));
    rd(4'h3, 0, d, r, lo, st);
    e = rq.pop_front();
    n++;
    if ({d, r} !== e || !lo) begin
      errs++; $display("FAIL misaligned_read got %h/%b exp %h/%b", d, r, e[33:2], e[1:0]);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge ACLK);
    bus.ARADDR = 4'h4; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    n++;
    if (bus.RVALID || bus.BVALID || bus.RDATA !== 32'h0) begin
      errs++; $display("FAIL reset_mid got rv=%0d bv=%0d rdata=%h exp 0/0/0", bus.RVALID, bus.BVALID, bus.RDATA);
    end
    check_regs("reset_mid");
  endtask

  initial begin
    ARESET = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    test_reset;
    test_read_zero;
    test_write_read("same_cycle", 4'h4, 32'hDEADBEEF, 0, 0, 0);
    test_write_read("w_first", 4'hC, 32'h12345678, 3, 0, 0);
    test_write_read("backpressure", 4'h0, 32'hCAFEF00D, 0, 5, 4);
    test_write_read("seed_reg2", 4'h8, 32'h11112222, 1, 0, 0);
    test_same_edge;
    test_misaligned;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
